// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a fixed clock-divide baud rate.
// Done is a ready level for CPU polling; Active spans start bit through stop bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       i_Clock,
    input  logic       resetn,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_data;
    logic          r_serial;
    logic          r_active;
    logic          r_done;
    logic          w_serial;
    logic          w_active;
    logic          w_done;
    logic          w_bit_end;

    assign w_bit_end   = (r_clk_cnt == LAST);
    assign o_Tx_Serial = r_serial;
    assign o_Tx_Active = r_active;
    assign o_Tx_Done   = r_done;

    // State and registered outputs; outputs lag the state by one edge so the
    // line changes exactly on the edge after each transition decision.
    always_ff @(posedge i_Clock) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_serial <= w_serial;
            r_active <= w_active;
            r_done   <= w_done;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!resetn) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (i_Tx_DV) r_data <= i_Tx_Byte;
                end
                S_START, S_STOP: begin
                    r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CW'(1);
                end
                S_DATA: begin
                    r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CW'(1);
                    if (w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;
                end
                default: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_Tx_DV) w_next = S_START;
            S_START:   if (w_bit_end) w_next = S_DATA;
            S_DATA:    if (w_bit_end && (r_bit_idx == 3'd7)) w_next = S_STOP;
            S_STOP:    if (w_bit_end) w_next = S_CLEANUP;
            S_CLEANUP: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_serial = 1'b1;
        w_active = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_active = i_Tx_DV;
                w_done   = !i_Tx_DV;
            end
            S_START: begin
                w_serial = 1'b0;
                w_active = 1'b1;
            end
            S_DATA: begin
                w_serial = r_data[r_bit_idx];
                w_active = 1'b1;
            end
            S_STOP: begin
                w_active = !w_bit_end;
            end
            S_CLEANUP: begin
                w_done = 1'b1;
            end
            default: begin
                w_done = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (short and default divide) checked every
// cycle against a frame-timing model derived from the acceptance edge.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB_A = 4;
    localparam int CPB_B = 234;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_a = 1'b0, dv_a = 1'b0;
    logic [7:0] byte_a = 8'h00;
    logic       ser_a, act_a, done_a;
    logic       rstn_b = 1'b0, dv_b = 1'b0;
    logic [7:0] byte_b = 8'h00;
    logic       ser_b, act_b, done_b;

    uart_tx #(.CLKS_PER_BIT(CPB_A)) u_dut_a (
        .i_Clock(clk), .resetn(rstn_a), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
        .o_Tx_Serial(ser_a), .o_Tx_Active(act_a), .o_Tx_Done(done_a)
    );

    uart_tx #(.CLKS_PER_BIT(CPB_B)) u_dut_b (
        .i_Clock(clk), .resetn(rstn_b), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
        .o_Tx_Serial(ser_b), .o_Tx_Active(act_b), .o_Tx_Done(done_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a frame accepted at edge acc puts frame bit k = {0, d[0..7], 1}[k]
    // on the line after edges acc+1+k*cpb .. acc+(k+1)*cpb; rel = edge - acc - 1.
    function automatic logic exp_ser(input int cpb, input bit have, input int rel,
                                     input logic [7:0] b);
        int k;
        if (!have || rel < 0 || rel >= 10 * cpb) return 1'b1;
        k = rel / cpb;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic exp_done(input int cpb, input bit have, input int rel);
        return !(have && rel >= -1 && rel <= 10 * cpb - 1);
    endfunction

    function automatic logic exp_act(input int cpb, input bit have, input int rel);
        return have && rel >= -1 && rel < 10 * cpb - 1;
    endfunction

    int         cyc = 0;
    bit         have_a = 0, have_b = 0;
    int         acc_a = 0, acc_b = 0;
    logic [7:0] mb_a = 8'h00, mb_b = 8'h00;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rstn_a) have_a = 0;
        else if (dv_a && (!have_a || cyc > acc_a + 10 * CPB_A + 1)) begin
            have_a = 1; acc_a = cyc; mb_a = byte_a;
        end
        if (!rstn_b) have_b = 0;
        else if (dv_b && (!have_b || cyc > acc_b + 10 * CPB_B + 1)) begin
            have_b = 1; acc_b = cyc; mb_b = byte_b;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("a_serial", 32'(ser_a),  32'(exp_ser(CPB_A, have_a, cyc - acc_a - 1, mb_a)));
            check("a_done",   32'(done_a), 32'(exp_done(CPB_A, have_a, cyc - acc_a - 1)));
            check("a_active", 32'(act_a),  32'(exp_act(CPB_A, have_a, cyc - acc_a - 1)));
            check("b_serial", 32'(ser_b),  32'(exp_ser(CPB_B, have_b, cyc - acc_b - 1, mb_b)));
            check("b_done",   32'(done_b), 32'(exp_done(CPB_B, have_b, cyc - acc_b - 1)));
            check("b_active", 32'(act_b),  32'(exp_act(CPB_B, have_b, cyc - acc_b - 1)));
        end
    end

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (done_a !== 1'b1 && n < budget) begin
            n++;
            @(negedge clk);
        end
        check("a_done_wait", 32'(done_a), 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_serial", 32'(ser_a), 32'd1);
        check("rst_done",   32'(done_a), 32'd1);
        check("rst_active", 32'(act_a), 32'd0);
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        @(negedge clk);

        // single byte, one-cycle strobe
        byte_a = 8'h41; dv_a = 1'b1;
        @(negedge clk);
        dv_a = 1'b0;
        n = 0;
        while (done_a == 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("a_done_low_len", 32'(n), 32'd41);
        repeat (3) @(negedge clk);

        // strobe with a different byte during the data phase is dropped
        byte_a = 8'h55; dv_a = 1'b1;
        @(negedge clk);
        dv_a = 1'b0;
        repeat (14) @(negedge clk);
        byte_a = 8'hAA; dv_a = 1'b1;
        repeat (3) @(negedge clk);
        dv_a = 1'b0;
        wait_done_a(100);
        repeat (6) @(negedge clk);

        // held strobe: back-to-back frames, byte swapped when Done rises
        byte_a = 8'h00; dv_a = 1'b1;
        @(negedge clk);
        wait_done_a(100);
        byte_a = 8'hFF;
        @(negedge clk);
        wait_done_a(100);
        dv_a = 1'b0;
        repeat (4) @(negedge clk);

        // reset during data bit 3
        byte_a = 8'($urandom); dv_a = 1'b1;
        @(negedge clk);
        dv_a = 1'b0;
        repeat (17) @(negedge clk);
        rstn_a = 1'b0;
        @(negedge clk);
        check("midrst_serial", 32'(ser_a), 32'd1);
        check("midrst_done",   32'(done_a), 32'd1);
        check("midrst_active", 32'(act_a), 32'd0);
        rstn_a = 1'b1;
        byte_a = 8'hC3; dv_a = 1'b1;
        @(negedge clk);
        dv_a = 1'b0;
        wait_done_a(100);
        repeat (3) @(negedge clk);

        // random strobes, bytes and occasional resets
        for (int i = 0; i < 1500; i++) begin
            dv_a   = ($urandom_range(0, 9) == 0);
            byte_a = 8'($urandom);
            rstn_a = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        dv_a = 1'b0; rstn_a = 1'b1;
        wait_done_a(100);

        // default divide
        byte_b = 8'h0A; dv_b = 1'b1;
        @(negedge clk);
        dv_b = 1'b0;
        byte_b = 8'hFF;
        n = 0;
        while (act_b == 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("b_frame_len", 32'(n), 32'd2340);
        repeat (5) @(negedge clk);
        check("b_done_end", 32'(done_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
